// File: rtl/ov9281_config_ctrl_pkg.sv
// ov9281_config_ctrl_pkg
// Shared definitions for the OV9281 register-configuration sequencer:
//   - cfg_state_e     : sequencer state encoding
//   - SOFT_RST_WORD   : LUT word {addr, val} that triggers the soft-reset settle wait
//   - *_DEF           : parameter defaults used by ov9281_config_ctrl
//   - max_u()         : constant helper for sizing the delay counter
package ov9281_config_ctrl_pkg;

    localparam int unsigned REG_NUM_DEF   = 126;
    localparam int unsigned PWR_DLY_DEF   = 20000;
    localparam int unsigned SRST_DLY_DEF  = 5000;
    localparam int unsigned MAX_RETRY_DEF = 3;

    localparam logic [23:0] SOFT_RST_WORD = 24'h010301;

    typedef enum logic [2:0] {
        PWR_WAIT,
        ISSUE,
        WAIT,
        SRST_WAIT,
        NEXT,
        DONE,
        ERROR
    } cfg_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ov9281_config_ctrl.sv
// ov9281_config_ctrl
// Walks an external register LUT and writes every entry to the OV9281 through an
// SCCB master, with a power-up wait, a settle wait after the soft-reset write and
// bounded retries on NACK.
//
// Ports:
//   sys_clk      in   clock
//   sys_rst_n    in   asynchronous active-low reset
//   reg_index    out  [8:0]  LUT entry select
//   lut_data     in   [23:0] {reg_addr, reg_val} for reg_index (combinational LUT)
//   i2c_exec     out  one-cycle write-start pulse
//   i2c_addr     out  [15:0] register address, held until the next write
//   i2c_data     out  [7:0]  register value, held until the next write
//   i2c_done     in   one-cycle transfer-complete pulse
//   i2c_ack_err  in   NACK flag, valid with i2c_done
//   cfg_start    in   restart pulse, honoured only in DONE or ERROR
//   cfg_done     out  all entries written
//   cfg_err      out  retries exhausted
module ov9281_config_ctrl
    import ov9281_config_ctrl_pkg::*;
#(
    parameter int unsigned REG_NUM   = REG_NUM_DEF,
    parameter int unsigned PWR_DLY   = PWR_DLY_DEF,
    parameter int unsigned SRST_DLY  = SRST_DLY_DEF,
    parameter int unsigned MAX_RETRY = MAX_RETRY_DEF
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    output logic [8:0]  reg_index,
    input  logic [23:0] lut_data,
    output logic        i2c_exec,
    output logic [15:0] i2c_addr,
    output logic [7:0]  i2c_data,
    input  logic        i2c_done,
    input  logic        i2c_ack_err,
    input  logic        cfg_start,
    output logic        cfg_done,
    output logic        cfg_err
);

    localparam int unsigned CNT_RAW = $clog2(max_u(PWR_DLY, SRST_DLY) + 1);
    localparam int unsigned CNT_W   = (CNT_RAW > 0) ? CNT_RAW : 1;
    localparam int unsigned RTY_RAW = $clog2(MAX_RETRY + 1);
    localparam int unsigned RTY_W   = (RTY_RAW > 0) ? RTY_RAW : 1;

    // The ISSUE cycle counts as the last cycle of the power wait, so i2c_exec
    // rises exactly PWR_DLY cycles after reset release.
    localparam logic [CNT_W-1:0] PWR_LAST  = (PWR_DLY >= 2) ? CNT_W'(PWR_DLY - 2) : '0;
    localparam logic [CNT_W-1:0] SRST_LAST = (SRST_DLY >= 1) ? CNT_W'(SRST_DLY - 1) : '0;
    localparam logic [RTY_W-1:0] RTY_MAX   = RTY_W'(MAX_RETRY);
    localparam logic [8:0]       LAST_IDX  = 9'(REG_NUM - 1);

    cfg_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RTY_W-1:0] retry_q, retry_d;
    logic [8:0]       index_d;
    logic             exec_d;
    logic [15:0]      addr_d;
    logic [7:0]       data_d;
    logic             is_last;

    assign is_last = (reg_index == LAST_IDX);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        index_d = reg_index;
        exec_d  = 1'b0;
        addr_d  = i2c_addr;
        data_d  = i2c_data;

        unique case (state_q)
            PWR_WAIT: begin
                if (cnt_q >= PWR_LAST) begin
                    cnt_d   = '0;
                    state_d = ISSUE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // lut_data has had at least one full cycle to settle on reg_index here;
            // the word is captured together with the start pulse.
            ISSUE: begin
                exec_d  = 1'b1;
                addr_d  = lut_data[23:8];
                data_d  = lut_data[7:0];
                state_d = WAIT;
            end

            WAIT: begin
                if (i2c_done) begin
                    if (i2c_ack_err) begin
                        if (retry_q < RTY_MAX) begin
                            retry_d = retry_q + 1'b1;
                            state_d = ISSUE;
                        end else begin
                            state_d = ERROR;
                        end
                    end else begin
                        retry_d = '0;
                        if ({i2c_addr, i2c_data} == SOFT_RST_WORD) begin
                            cnt_d   = '0;
                            state_d = SRST_WAIT;
                        end else if (is_last) begin
                            state_d = DONE;
                        end else begin
                            index_d = reg_index + 9'd1;
                            state_d = NEXT;
                        end
                    end
                end
            end

            SRST_WAIT: begin
                if (cnt_q >= SRST_LAST) begin
                    cnt_d = '0;
                    if (is_last) begin
                        state_d = DONE;
                    end else begin
                        index_d = reg_index + 9'd1;
                        state_d = NEXT;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            NEXT: state_d = ISSUE;

            DONE, ERROR: begin
                if (cfg_start) begin
                    index_d = '0;
                    retry_d = '0;
                    cnt_d   = '0;
                    state_d = ISSUE;
                end
            end

            default: state_d = PWR_WAIT;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= PWR_WAIT;
            cnt_q     <= '0;
            retry_q   <= '0;
            reg_index <= '0;
            i2c_exec  <= 1'b0;
            i2c_addr  <= '0;
            i2c_data  <= '0;
            cfg_done  <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            reg_index <= index_d;
            i2c_exec  <= exec_d;
            i2c_addr  <= addr_d;
            i2c_data  <= data_d;
            // Flags are registered from the next state so they track it exactly.
            cfg_done  <= (state_d == DONE);
            cfg_err   <= (state_d == ERROR);
        end
    end

endmodule

// File: tb/tb_ov9281_config_ctrl.sv
// Testbench for ov9281_config_ctrl with a 4-entry LUT and an SCCB responder that
// answers every write 20 cycles after i2c_exec, NACKing entry 2 on demand.
module tb_ov9281_config_ctrl;

    localparam int unsigned REG_NUM   = 4;
    localparam int unsigned PWR_DLY   = 10;
    localparam int unsigned SRST_DLY  = 5;
    localparam int unsigned MAX_RETRY = 3;
    localparam int          RESP_LAT  = 20;
    // exec-to-exec spacing: 20-cycle reply, done cycle, NEXT, ISSUE
    localparam int          GAP_NORM  = RESP_LAT + 3;
    localparam int          GAP_RETRY = RESP_LAT + 2;
    localparam int          GAP_SRST  = RESP_LAT + 3 + SRST_DLY;

    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [8:0]  reg_index;
    logic [23:0] lut_data;
    logic        i2c_exec;
    logic [15:0] i2c_addr;
    logic [7:0]  i2c_data;
    logic        i2c_done;
    logic        i2c_ack_err;
    logic        cfg_start = 1'b0;
    logic        cfg_done;
    logic        cfg_err;

    logic resp_done = 1'b0;
    logic resp_ack  = 1'b0;
    logic spur_done = 1'b0;
    logic spur_ack  = 1'b0;

    assign i2c_done    = resp_done | spur_done;
    assign i2c_ack_err = resp_ack | spur_ack;

    always_comb begin
        case (reg_index)
            9'd0:    lut_data = 24'h010000;
            9'd1:    lut_data = 24'h010301;
            9'd2:    lut_data = 24'h380805;
            9'd3:    lut_data = 24'h010001;
            default: lut_data = 24'hffffff;
        endcase
    end

    ov9281_config_ctrl #(
        .REG_NUM  (REG_NUM),
        .PWR_DLY  (PWR_DLY),
        .SRST_DLY (SRST_DLY),
        .MAX_RETRY(MAX_RETRY)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .reg_index  (reg_index),
        .lut_data   (lut_data),
        .i2c_exec   (i2c_exec),
        .i2c_addr   (i2c_addr),
        .i2c_data   (i2c_data),
        .i2c_done   (i2c_done),
        .i2c_ack_err(i2c_ack_err),
        .cfg_start  (cfg_start),
        .cfg_done   (cfg_done),
        .cfg_err    (cfg_err)
    );

    initial forever #5 sys_clk = ~sys_clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboard of expected writes; gap is cycles since the previous exec
    // (or since the marked reset release / cfg_start), -1 = not checked.
    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        int          gap;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         e;
    int          cyc       = 0;
    int          mark      = 0;
    int          nack_left = 0;
    int          resp_cnt  = 0;
    logic [15:0] cur_addr  = '0;

    task automatic push(input logic [15:0] a, input logic [7:0] d, input int gap);
        wr_t w;
        w.addr = a;
        w.data = d;
        w.gap  = gap;
        exp_q.push_back(w);
    endtask

    // Expected write list for a full run with `nacks` NACKs on entry 2.
    task automatic push_run(input int nacks, input int first_gap);
        int pulses;
        pulses = (nacks > int'(MAX_RETRY)) ? int'(MAX_RETRY) + 1 : nacks + 1;
        push(16'h0100, 8'h00, first_gap);
        push(16'h0103, 8'h01, GAP_NORM);
        push(16'h3808, 8'h05, GAP_SRST);
        for (int i = 1; i < pulses; i++) push(16'h3808, 8'h05, GAP_RETRY);
        if (nacks <= int'(MAX_RETRY)) push(16'h0100, 8'h01, GAP_NORM);
    endtask

    // Monitor + SCCB responder: samples 1 time unit after each rising edge.
    initial forever begin
        @(posedge sys_clk);
        #1;
        cyc++;
        resp_done = 1'b0;
        resp_ack  = 1'b0;
        if (!sys_rst_n) begin
            resp_cnt = 0;
        end else if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
                resp_done = 1'b1;
                if (cur_addr == 16'h3808 && nack_left > 0) begin
                    resp_ack = 1'b1;
                    nack_left--;
                end
            end
        end
        if (i2c_exec) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_exec: actual addr=%h data=%h required no write",
                         i2c_addr, i2c_data);
            end else begin
                e = exp_q.pop_front();
                check("exec_addr", 32'(i2c_addr), 32'(e.addr));
                check("exec_data", 32'(i2c_data), 32'(e.data));
                if (e.gap >= 0) check("exec_gap", 32'(cyc - mark), 32'(e.gap));
                check("index_range", 32'(reg_index <= 9'(REG_NUM - 1)), 32'd1);
            end
            mark     = cyc;
            resp_cnt = RESP_LAT;
            cur_addr = i2c_addr;
        end
    end

    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        exp_q.delete();
        nack_left = 0;
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        mark      = cyc;
    endtask

    task automatic wait_end(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !(cfg_done || cfg_err)) && n < 3000) begin
            @(negedge sys_clk);
            n++;
        end
        if (n >= 3000) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: actual pending=%0d required 0 and flag set", name,
                     exp_q.size());
        end
        // quiet period: any further exec is flagged by the monitor
        repeat (40) @(negedge sys_clk);
    endtask

    task automatic wait_pending(input int left);
        int n;
        n = 0;
        while (exp_q.size() > left && n < 3000) begin
            @(negedge sys_clk);
            n++;
        end
        if (n >= 3000) begin
            total++;
            bad++;
            $display("FAIL wait_pending: actual pending=%0d required %0d", exp_q.size(), left);
        end
    endtask

    typedef struct {
        int         nacks;
        logic       exp_done;
        logic       exp_err;
        logic [8:0] exp_idx;
    } vec_t;

    vec_t vecs[4];

    initial begin
        vecs[0] = '{0, 1'b1, 1'b0, 9'd3};
        vecs[1] = '{2, 1'b1, 1'b0, 9'd3};
        vecs[2] = '{3, 1'b1, 1'b0, 9'd3};
        vecs[3] = '{4, 1'b0, 1'b1, 9'd2};

        // Reset state
        repeat (2) @(negedge sys_clk);
        check("rst_exec", 32'(i2c_exec), 32'd0);
        check("rst_addr", 32'(i2c_addr), 32'd0);
        check("rst_data", 32'(i2c_data), 32'd0);
        check("rst_index", 32'(reg_index), 32'd0);
        check("rst_done", 32'(cfg_done), 32'd0);
        check("rst_err", 32'(cfg_err), 32'd0);

        for (int v = 0; v < 4; v++) begin
            do_reset();
            nack_left = vecs[v].nacks;
            push_run(vecs[v].nacks, int'(PWR_DLY));
            wait_end("run");
            check("end_done", 32'(cfg_done), 32'(vecs[v].exp_done));
            check("end_err", 32'(cfg_err), 32'(vecs[v].exp_err));
            check("end_index", 32'(reg_index), 32'(vecs[v].exp_idx));
            if (vecs[v].exp_err) begin
                // restart from ERROR goes straight to entry 0, no power wait
                @(negedge sys_clk);
                cfg_start = 1'b1;
                mark      = cyc;
                push_run(0, 2);
                @(negedge sys_clk);
                cfg_start = 1'b0;
                check("restart_err_clr", 32'(cfg_err), 32'd0);
                check("restart_index", 32'(reg_index), 32'd0);
                wait_end("restart");
                check("restart_done", 32'(cfg_done), 32'd1);
                check("restart_err", 32'(cfg_err), 32'd0);
            end
        end

        // Spurious i2c_done in PWR_WAIT, cfg_start during WAIT: both ignored
        do_reset();
        push_run(0, int'(PWR_DLY));
        repeat (3) @(negedge sys_clk);
        spur_done = 1'b1;
        spur_ack  = 1'b1;
        @(negedge sys_clk);
        spur_done = 1'b0;
        spur_ack  = 1'b0;
        check("spur_index", 32'(reg_index), 32'd0);
        check("spur_err", 32'(cfg_err), 32'd0);
        wait_pending(3);
        repeat (4) @(negedge sys_clk);
        cfg_start = 1'b1;
        @(negedge sys_clk);
        cfg_start = 1'b0;
        check("start_wait_index", 32'(reg_index), 32'd0);
        check("start_wait_addr", 32'(i2c_addr), 32'h0100);
        check("start_wait_exec", 32'(i2c_exec), 32'd0);
        wait_end("spur");
        check("spur_end_done", 32'(cfg_done), 32'd1);

        // Reset asserted in WAIT of entry 2 aborts and restarts the whole sequence
        do_reset();
        push_run(0, int'(PWR_DLY));
        wait_pending(1);
        repeat (5) @(negedge sys_clk);
        #2;
        sys_rst_n = 1'b0;
        #1;
        check("abort_addr", 32'(i2c_addr), 32'd0);
        check("abort_data", 32'(i2c_data), 32'd0);
        check("abort_index", 32'(reg_index), 32'd0);
        check("abort_exec", 32'(i2c_exec), 32'd0);
        check("abort_done", 32'(cfg_done), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        mark      = cyc;
        push_run(0, int'(PWR_DLY));
        wait_end("abort");
        check("abort_end_done", 32'(cfg_done), 32'd1);
        check("abort_end_index", 32'(reg_index), 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
